// File: rtl/wf_pkg.sv
// Shared constants for the waveform playback sequencer.
// Holds the FSM encoding, the minimum sample period and the status-word layout.
package wf_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_FETCH = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   // FETCH + WAIT take two clocks, so HOLD needs at least one of its own.
   localparam int WF_MIN_PERIOD = 3;

   localparam int STAT_LOOP_LSB = 16;
   localparam int STAT_IDX_LSB  = 0;

   function automatic logic [31:0] wf_status(input logic [15:0] loops, input logic [15:0] idx);
      logic [31:0] w;
      w = '0;
      w[STAT_LOOP_LSB +: 16] = loops;
      w[STAT_IDX_LSB +: 16]  = idx;
      return w;
   endfunction

endpackage

// File: rtl/wf_period_timer.sv
// Loadable down-counter; tc is high on the last enabled cycle of a loaded count.
// Latency: load takes effect next clock; tc is combinational from the count.
// Backpressure: none, the counter only advances while en is high.
module wf_period_timer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             tc
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign tc = en && (cnt == WIDTH'(1));

endmodule

// File: rtl/wf_player_ctrl.sv
// Waveform playback sequencer: reads one DPBRAM sample per period, loops, reports progress.
// Latency: start sampled at t0 gives the first valid pulse at t4, then one every max(period,3) clocks.
// Backpressure: none; start=0 aborts at once. WF_ZERO_ON_STOP_EN drives a zero sample on stop.
module wf_player_ctrl
   import wf_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 16,
   parameter int PERIOD_WIDTH = 32
) (
   input  logic                    S_AXI_ACLK,
   input  logic                    S_AXI_ARESETN,
   input  logic                    i_wf_mode_start,
   input  logic                    i_wf_write_en,
   input  logic [ADDR_WIDTH:0]     i_wf_length,
   input  logic [PERIOD_WIDTH-1:0] i_wf_period,
   input  logic [15:0]             i_wf_loop_num,
   output logic                    o_bram_rd_en,
   output logic [ADDR_WIDTH-1:0]   o_bram_rd_addr,
   input  logic [DATA_WIDTH-1:0]   i_bram_rd_data,
   output logic [DATA_WIDTH-1:0]   o_wf_sample,
   output logic                    o_wf_sample_valid,
   output logic                    o_wf_busy,
   output logic                    o_wf_done,
   output logic                    o_wf_err,
   output logic [31:0]             o_wf_read_data_num
);

`ifdef WF_ZERO_ON_STOP_EN
   localparam bit ZERO_ON_STOP = 1'b1;
`else
   localparam bit ZERO_ON_STOP = 1'b0;
`endif

   localparam logic [ADDR_WIDTH:0]     MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]     LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0]   IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PERIOD_WIDTH-1:0] MIN_P   = PERIOD_WIDTH'(WF_MIN_PERIOD);
   localparam logic [PERIOD_WIDTH-1:0] PIPE_P  = PERIOD_WIDTH'(2);

   logic [2:0]              state;
   logic                    armed;
   logic [ADDR_WIDTH:0]     len_q;
   logic [PERIOD_WIDTH-1:0] per_q;
   logic [15:0]             loops_q;
   logic [ADDR_WIDTH-1:0]   index;
   logic [15:0]             loop_cnt;
   logic [DATA_WIDTH-1:0]   sample;
   logic                    valid;
   logic                    err;

   logic [PERIOD_WIDTH-1:0] per_eff;
   logic                    cfg_bad;
   logic                    last_idx;
   logic                    run_state;
   logic [15:0]             loop_nxt;
   logic                    hold_end;

   always_comb begin
      per_eff   = (i_wf_period < MIN_P) ? MIN_P : i_wf_period;
      cfg_bad   = (i_wf_length == '0) || (i_wf_length > MAX_LEN);
      last_idx  = ({1'b0, index} == (len_q - LEN_ONE));
      run_state = (state == ST_LOAD) || (state == ST_FETCH) ||
                  (state == ST_WAIT) || (state == ST_HOLD);
      loop_nxt  = (loop_cnt == 16'hFFFF) ? loop_cnt : loop_cnt + 16'd1;
   end

   // HOLD covers the period minus the two FETCH/WAIT clocks.
   wf_period_timer #(
      .WIDTH (PERIOD_WIDTH)
   ) u_hold_timer (
      .clk      (S_AXI_ACLK),
      .rst_n    (S_AXI_ARESETN),
      .load     (state == ST_WAIT),
      .load_val (per_q - PIPE_P),
      .en       (state == ST_HOLD),
      .tc       (hold_end)
   );

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state    <= ST_IDLE;
         armed    <= 1'b1;
         len_q    <= '0;
         per_q    <= '0;
         loops_q  <= '0;
         index    <= '0;
         loop_cnt <= '0;
         sample   <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!i_wf_mode_start) begin
            armed <= 1'b1;
         end
         if (run_state && !i_wf_mode_start) begin
            state <= ST_IDLE;
            if (ZERO_ON_STOP) begin
               sample <= '0;
               valid  <= 1'b1;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_wf_mode_start && armed && !i_wf_write_en) begin
                     state <= ST_LOAD;
                     armed <= 1'b0;
                  end
               end
               ST_LOAD: begin
                  len_q    <= i_wf_length;
                  per_q    <= per_eff;
                  loops_q  <= i_wf_loop_num;
                  index    <= '0;
                  loop_cnt <= '0;
                  if (cfg_bad) begin
                     err   <= 1'b1;
                     state <= ST_DONE;
                     if (ZERO_ON_STOP) begin
                        sample <= '0;
                        valid  <= 1'b1;
                     end
                  end else begin
                     state <= ST_FETCH;
                  end
               end
               ST_FETCH: state <= ST_WAIT;
               ST_WAIT: begin
                  sample <= i_bram_rd_data;
                  valid  <= 1'b1;
                  state  <= ST_HOLD;
               end
               ST_HOLD: begin
                  if (hold_end) begin
                     if (last_idx) begin
                        index    <= '0;
                        loop_cnt <= loop_nxt;
                        if ((loops_q != 16'd0) && (loop_nxt == loops_q)) begin
                           state <= ST_DONE;
                           if (ZERO_ON_STOP) begin
                              sample <= '0;
                              valid  <= 1'b1;
                           end
                        end else begin
                           state <= ST_FETCH;
                        end
                     end else begin
                        index <= index + IDX_ONE;
                        state <= ST_FETCH;
                     end
                  end
               end
               ST_DONE: begin
                  if (!i_wf_mode_start) begin
                     state <= ST_IDLE;
                     err   <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_bram_rd_en       = (state == ST_FETCH);
   assign o_bram_rd_addr     = index;
   assign o_wf_sample        = sample;
   assign o_wf_sample_valid  = valid;
   assign o_wf_busy          = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_HOLD);
   assign o_wf_done          = (state == ST_DONE);
   assign o_wf_err           = err;
   assign o_wf_read_data_num = wf_status(loop_cnt, 16'(index));

endmodule
